// File: rtl/data_mem_ctrl.sv
// LSU data memory controller: single outstanding access, programmable wait
// states, byte-lane writes, one-cycle registered response.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        busy_o
);

    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [29:0] word_idx;
    logic [IW-1:0] mem_idx;
    logic        acc_err;
    logic        gnt;
    logic        do_write;

    assign word_idx = addr_q[31:2];
    assign mem_idx  = addr_q[IW+1:2];
    assign acc_err  = (addr_q[1:0] != 2'b00)
                   || ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
    assign gnt      = data_req_i && (state_q == S_IDLE) && !rst_i;
    // A reset landing on the ACCESS edge aborts the write as well.
    assign do_write = (state_q == S_ACCESS) && we_q && !acc_err && !rst_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt) begin
                    we_d    = data_we_i;
                    be_d    = data_be_i;
                    addr_d  = data_addr_i;
                    wdata_d = data_wdata_i;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rvalid_d = 1'b1;
                err_d    = acc_err;
                rdata_d  = (!we_q && !acc_err) ? mem_q[mem_idx] : 32'd0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Array is deliberately outside reset.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one instance with one wait state,
// one with zero wait states for back-to-back timing.
module tb_data_mem_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    logic        req1 = 0, we1 = 0;
    logic [3:0]  be1 = 0;
    logic [31:0] addr1 = 0, wd1 = 0;
    logic        gnt1, rv1, err1, busy1;
    logic [31:0] rd1;

    logic        req0 = 0, we0 = 0;
    logic [3:0]  be0 = 0;
    logic [31:0] addr0 = 0, wd0 = 0;
    logic        gnt0, rv0, err0, busy0;
    logic [31:0] rd0;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req1), .data_we_i(we1), .data_be_i(be1),
        .data_addr_i(addr1), .data_wdata_i(wd1),
        .data_gnt_o(gnt1), .data_rvalid_o(rv1), .data_rdata_o(rd1),
        .data_err_o(err1), .busy_o(busy1)
    );

    data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req0), .data_we_i(we0), .data_be_i(be0),
        .data_addr_i(addr0), .data_wdata_i(wd0),
        .data_gnt_o(gnt0), .data_rvalid_o(rv0), .data_rdata_o(rd0),
        .data_err_o(err0), .busy_o(busy0)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    // Response monitors: pop one expectation per rvalid pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rv1) begin
                if (q1.size() == 0) begin
                    check("dut1_spurious_rvalid", 32'(rv1), 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("dut1_latency", 32'(cyc), 32'(e.cyc));
                    check("dut1_rdata", rd1, e.rdata);
                    check("dut1_err", 32'(err1), 32'(e.err));
                end
            end else begin
                check("dut1_idle_rdata", rd1, 32'd0);
                check("dut1_idle_err", 32'(err1), 32'd0);
            end
            if (rv0) begin
                if (q0.size() == 0) begin
                    check("dut0_spurious_rvalid", 32'(rv0), 32'd0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("dut0_latency", 32'(cyc), 32'(e.cyc));
                    check("dut0_rdata", rd0, e.rdata);
                    check("dut0_err", 32'(err0), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clk);
        check("dut1_drain", 32'(q1.size()), 32'd0);
    endtask

    // Issue one request on dut1; returns the grant edge number.
    task automatic do_req(input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit push, output int t_gnt);
        bit got = 0;
        exp_t e;
        @(negedge clk);
        req1 = 1; we1 = we; be1 = be; addr1 = addr; wd1 = wd;
        t_gnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (gnt1) begin
                got = 1;
                t_gnt = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        check("dut1_grant", 32'(got), 32'd1);
        if (got && push) begin
            e.cyc = t_gnt + 1 + 1;
            e.rdata = exp_rd;
            e.err = exp_err;
            q1.push_back(e);
        end
        @(negedge clk);
        req1 = 0; we1 = ~we; be1 = 4'($urandom);
        addr1 = $urandom; wd1 = $urandom;
    endtask

    initial begin
        int t;
        int gt[3];
        int ng;
        req1 = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_rvalid", 32'(rv1), 32'd0);
        check("rst_rdata", rd1, 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        req1 = 0;
        @(negedge clk);
        rst = 0;
        mon_en = 1;

        do_req(1, 4'hF, 32'h20, 32'h0, 32'h0, 0, 1, t);
        wait_drain();
        do_req(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, t);
        wait_drain();
        do_req(0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, t);
        wait_drain();
        do_req(1, 4'b0100, 32'h10, 32'h5A5A5A5A, 32'h0, 0, 1, t);
        wait_drain();
        do_req(0, 4'h3, 32'h10, 32'h0, 32'hDE5ABEEF, 0, 1, t);
        wait_drain();
        do_req(1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 0, 1, t);
        wait_drain();
        do_req(0, 4'hF, 32'h10, 32'h0, 32'hDE5ABEEF, 0, 1, t);
        wait_drain();
        do_req(0, 4'hF, 32'h12, 32'h0, 32'h0, 1, 1, t);
        wait_drain();
        do_req(1, 4'hF, 32'h13, 32'h0, 32'h0, 1, 1, t);
        wait_drain();
        do_req(1, 4'hF, 32'h0, 32'h01234567, 32'h0, 0, 1, t);
        wait_drain();
        do_req(1, 4'hF, 32'h400, 32'hFFFFFFFF, 32'h0, 1, 1, t);
        wait_drain();
        do_req(0, 4'hF, 32'h400, 32'h0, 32'h0, 1, 1, t);
        wait_drain();
        do_req(0, 4'hF, 32'h0, 32'h0, 32'h01234567, 0, 1, t);
        wait_drain();
        do_req(0, 4'hF, 32'h10, 32'h0, 32'hDE5ABEEF, 0, 1, t);
        wait_drain();

        // Abort a write with reset while it sits in WAIT.
        do_req(1, 4'hF, 32'h20, 32'h11111111, 32'h0, 0, 0, t);
        check("abort_in_wait", 32'(busy1), 32'd1);
        rst = 1;
        @(negedge clk);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_rvalid", 32'(rv1), 32'd0);
        rst = 0;
        repeat (3) @(negedge clk);
        do_req(0, 4'hF, 32'h20, 32'h0, 32'h0, 0, 1, t);
        wait_drain();

        // Request presented while busy must be ignored.
        do_req(0, 4'hF, 32'h10, 32'h0, 32'hDE5ABEEF, 0, 1, t);
        req1 = 1; we1 = 1; be1 = 4'hF; addr1 = 32'h10; wd1 = 32'h0;
        #1;
        check("busy_nogrant_wait", 32'(gnt1), 32'd0);
        @(negedge clk);
        #1;
        check("busy_nogrant_acc", 32'(gnt1), 32'd0);
        check("busy_in_acc", 32'(busy1), 32'd1);
        @(negedge clk);
        req1 = 0;
        check("busy_idle", 32'(busy1), 32'd0);
        wait_drain();
        do_req(0, 4'hF, 32'h10, 32'h0, 32'hDE5ABEEF, 0, 1, t);
        wait_drain();

        // Zero wait states: write then two reads with req held high.
        @(negedge clk);
        req0 = 1; we0 = 1; be0 = 4'hF; addr0 = 32'h10; wd0 = 32'hCAFEF00D;
        ng = 0;
        for (int i = 0; i < 20 && ng < 3; i++) begin
            #1;
            if (gnt0) begin
                exp_t e;
                gt[ng] = cyc + 1;
                e.cyc = gt[ng] + 1;
                e.rdata = (ng == 0) ? 32'h0 : 32'hCAFEF00D;
                e.err = 0;
                q0.push_back(e);
                ng++;
            end
            @(negedge clk);
            if (ng >= 1) we0 = 0;
            if (ng >= 3) req0 = 0;
        end
        req0 = 0;
        check("dut0_grants", 32'(ng), 32'd3);
        if (ng == 3) begin
            check("dut0_gap1", 32'(gt[1] - gt[0]), 32'd2);
            check("dut0_gap2", 32'(gt[2] - gt[1]), 32'd2);
        end
        for (int i = 0; i < 20 && q0.size() != 0; i++) @(negedge clk);
        check("dut0_drain", 32'(q0.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
